tinyalu_arbiter: RTL

Round-robin arbiter and sequencer that shares one TinyALU between `NREQ` requesters. It accepts one operation at a time from the granted requester and drives the ALU's `A`/`B`/`op`/`start` with the TinyALU start/done protocol. It returns the 16-bit result to that requester. It sits between the requester-side agents and the single TinyALU datapath instance.

---
 rtl/tinyalu_pkg.sv | 34 +++
 rtl/tinyalu_rr_arbiter.sv | 34 +++
 rtl/tinyalu_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: opcode encoding, arbiter FSM states and opcode helper.
package tinyalu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  // True for opcodes that need the ALU datapath.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      add_op, and_op, xor_op, mul_op: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tinyalu_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after i_ptr.
module tinyalu_rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         i_valid,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_any
);

  localparam int unsigned IW = $clog2(NREQ);

  // Scan NREQ positions starting at the pointer, wrapping once.
  always_comb begin
    int unsigned j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = 32'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!o_any && (j == i) && i_valid[i]) begin
          o_any    = 1'b1;
          o_gnt[i] = 1'b1;
          o_idx    = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Round-robin sequencer sharing one TinyALU between NREQ requesters.
// Optional feature macro: TINYALU_ARB_TIMEOUT_EN (abort BUSY after TIMEOUT cycles).
module tinyalu_arbiter
  import tinyalu_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_A,
  input  logic [NREQ*DATA_W-1:0] req_B,
  input  logic [NREQ*OP_W-1:0]   req_op,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [RES_W-1:0]       rsp_result,
  output logic                   rsp_err,
  output logic [DATA_W-1:0]      alu_A,
  output logic [DATA_W-1:0]      alu_B,
  output logic [OP_W-1:0]        alu_op,
  output logic                   alu_start,
  input  logic                   alu_done,
  input  logic [RES_W-1:0]       alu_result
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_t        r_state, w_state_nxt;
  logic [IW-1:0]     r_ptr, w_ptr_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic [DATA_W-1:0] r_alu_a, w_alu_a_nxt;
  logic [DATA_W-1:0] r_alu_b, w_alu_b_nxt;
  logic [OP_W-1:0]   r_alu_op, w_alu_op_nxt;
  logic              r_alu_start, w_start_nxt;
  logic [NREQ-1:0]   r_rsp_valid, w_rsp_valid_nxt;
  logic [RES_W-1:0]  r_rsp_result, w_result_nxt;
  logic              r_rsp_err, w_err_nxt;

  logic [NREQ-1:0]   w_gnt;
  logic [IW-1:0]     w_gidx;
  logic              w_any;
  logic [DATA_W-1:0] w_sel_a, w_sel_b;
  logic [OP_W-1:0]   w_sel_op;
  logic [NREQ-1:0]   w_idx_onehot;

`ifdef TINYALU_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt, w_cnt_nxt;
`else
  // TIMEOUT only matters when the abort counter is built.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  tinyalu_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  assign w_idx_onehot = NREQ'(1) << r_idx;

  // Select the granted requester's operands and opcode.
  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gidx == IW'(i)) begin
        w_sel_a  = req_A[i*DATA_W +: DATA_W];
        w_sel_b  = req_B[i*DATA_W +: DATA_W];
        w_sel_op = req_op[i*OP_W +: OP_W];
      end
    end
  end

  // Next-state and next-output logic for IDLE/BUSY/RESP.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_idx_nxt       = r_idx;
    w_alu_a_nxt     = r_alu_a;
    w_alu_b_nxt     = r_alu_b;
    w_alu_op_nxt    = r_alu_op;
    w_start_nxt     = r_alu_start;
    w_rsp_valid_nxt = '0;
    w_result_nxt    = r_rsp_result;
    w_err_nxt       = r_rsp_err;
`ifdef TINYALU_ARB_TIMEOUT_EN
    w_cnt_nxt       = r_cnt;
`endif
    req_ready       = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          req_ready = reset_n ? w_gnt : '0;
          w_idx_nxt = w_gidx;
          w_ptr_nxt = (w_gidx == IW'(NREQ - 1)) ? '0 : w_gidx + IW'(1);
          if (is_alu_op(w_sel_op)) begin
            w_alu_a_nxt  = w_sel_a;
            w_alu_b_nxt  = w_sel_b;
            w_alu_op_nxt = w_sel_op;
            w_start_nxt  = 1'b1;
            w_state_nxt  = ARB_BUSY;
`ifdef TINYALU_ARB_TIMEOUT_EN
            w_cnt_nxt    = '0;
`endif
          end else begin
            // no_op completes cleanly; rst_op and unused codes report an error.
            w_state_nxt     = ARB_RESP;
            w_rsp_valid_nxt = w_gnt;
            w_result_nxt    = '0;
            w_err_nxt       = (w_sel_op != no_op);
          end
        end
      end
      ARB_BUSY: begin
        if (alu_done) begin
          w_start_nxt     = 1'b0;
          w_state_nxt     = ARB_RESP;
          w_rsp_valid_nxt = w_idx_onehot;
          w_result_nxt    = alu_result;
          w_err_nxt       = 1'b0;
        end
`ifdef TINYALU_ARB_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_start_nxt     = 1'b0;
          w_state_nxt     = ARB_RESP;
          w_rsp_valid_nxt = w_idx_onehot;
          w_result_nxt    = '0;
          w_err_nxt       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
`endif
      end
      ARB_RESP: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ARB_IDLE;
      r_ptr        <= '0;
      r_idx        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_alu_start  <= 1'b0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
`ifdef TINYALU_ARB_TIMEOUT_EN
      r_cnt        <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_idx        <= w_idx_nxt;
      r_alu_a      <= w_alu_a_nxt;
      r_alu_b      <= w_alu_b_nxt;
      r_alu_op     <= w_alu_op_nxt;
      r_alu_start  <= w_start_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_result <= w_result_nxt;
      r_rsp_err    <= w_err_nxt;
`ifdef TINYALU_ARB_TIMEOUT_EN
      r_cnt        <= w_cnt_nxt;
`endif
    end
  end

  assign alu_A      = r_alu_a;
  assign alu_B      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign alu_start  = r_alu_start;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;

endmodule
